shared_reg_arbiter: RTL and testbench

//  Round-robin write arbiter and sequencer for one shared WIDTH-bit D-FF register (Q/Q_bar pair).
//  N_REQ requesters compete for write access. The block grants one requester at a time,

---
 rtl/shared_reg_arbiter.sv | 128 ++++++++++++
 tb/tb_shared_reg_arbiter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/shared_reg_arbiter.sv
// Round-robin write arbiter for one shared WIDTH-bit register (Q/Q_bar pair).
// Grants one requester at a time, loads its data, acks each write, supports bounded locked bursts.
module shared_reg_arbiter #(
    parameter int N_REQ    = 4,
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ-1:0]       lock,
    input  logic [N_REQ*WIDTH-1:0] wdata,
    output logic [N_REQ-1:0]       gnt,
    output logic [WIDTH-1:0]       Q,
    output logic [WIDTH-1:0]       Q_bar,
    output logic                   wr_ack,
    output logic                   busy,
    output logic                   state_o
);

    localparam int IDXW = $clog2(N_REQ);
    localparam int HW   = $clog2(MAX_HOLD + 1);

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [IDXW-1:0]   g_q, g_d;
    logic [IDXW-1:0]   last_q, last_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic [WIDTH-1:0]  q_q, q_d;
    logic              ack_q, ack_d;

    logic [IDXW-1:0]   pick_from;
    logic [IDXW-1:0]   sel;
    logic              rel;

    // First requester after 'from_idx' with wrap; 'from_idx' itself is searched last.
    function automatic logic [IDXW-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                                input logic [IDXW-1:0] from_idx);
        logic [IDXW-1:0] pick;
        logic            found;
        int              idx;
        pick  = from_idx;
        found = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = (int'(from_idx) + i) % N_REQ;
            if (!found && r[idx]) begin
                pick  = IDXW'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign pick_from = (state_q == GRANT) ? g_q : last_q;
    assign sel       = rr_pick(req, pick_from);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        g_d     = g_q;
        last_d  = last_q;
        hold_d  = hold_q;
        q_d     = q_q;
        ack_d   = 1'b0;
        rel     = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    gnt_d   = N_REQ'(1) << sel;
                    g_d     = sel;
                    hold_d  = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (req[g_q]) begin
                    q_d    = wdata[g_q*WIDTH +: WIDTH];
                    ack_d  = 1'b1;
                    hold_d = hold_q + HW'(1);
                end
                rel = !req[g_q] || !lock[g_q] || ((int'(hold_q) + 1) == MAX_HOLD);
                if (rel) begin
                    last_d = g_q;
                    hold_d = '0;
                    // Hand over directly to avoid an idle bubble between grants.
                    if (|req) begin
                        gnt_d = N_REQ'(1) << sel;
                        g_d   = sel;
                    end else begin
                        gnt_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            g_q     <= '0;
            last_q  <= IDXW'(N_REQ - 1);
            hold_q  <= '0;
            q_q     <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            g_q     <= g_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
            q_q     <= q_d;
            ack_q   <= ack_d;
        end
    end

    assign gnt     = gnt_q;
    assign Q       = q_q;
    assign Q_bar   = ~q_q;
    assign wr_ack  = ack_q;
    assign busy    = (state_q == GRANT);
    assign state_o = state_q;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed bench for shared_reg_arbiter: reset, single write, round robin,
// lock limit, request drop and reset mid-grant, with hand-computed expectations.
module tb_shared_reg_arbiter;

    localparam int N_REQ    = 4;
    localparam int WIDTH    = 8;
    localparam int MAX_HOLD = 4;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [N_REQ-1:0]       req;
    logic [N_REQ-1:0]       lock;
    logic [N_REQ*WIDTH-1:0] wdata;
    logic [N_REQ-1:0]       gnt;
    logic [WIDTH-1:0]       Q;
    logic [WIDTH-1:0]       Q_bar;
    logic                   wr_ack;
    logic                   busy;
    logic                   state_o;

    int n_checks = 0;
    int n_pass   = 0;

    shared_reg_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .lock    (lock),
        .wdata   (wdata),
        .gnt     (gnt),
        .Q       (Q),
        .Q_bar   (Q_bar),
        .wr_ack  (wr_ack),
        .busy    (busy),
        .state_o (state_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic do_reset();
        req   = '0;
        lock  = '0;
        wdata = '0;
        rst   = 1'b1;
        tick();
        rst   = 1'b0;
    endtask

    task automatic check_idle_reset(input string tag);
        check({tag, "_gnt"},   32'(gnt),    32'h0);
        check({tag, "_q"},     32'(Q),      32'h00);
        check({tag, "_qbar"},  32'(Q_bar),  32'hFF);
        check({tag, "_ack"},   32'(wr_ack), 32'h0);
        check({tag, "_busy"},  32'(busy),   32'h0);
    endtask

    logic [3:0] rr_gnt_exp [5];
    logic [7:0] rr_q_exp   [5];

    initial begin
        rst   = 1'b1;
        req   = '0;
        lock  = '0;
        wdata = '0;

        // Reset held for two cycles with all requests asserted
        req = 4'b1111;
        tick();
        check_idle_reset("rst_c1");
        tick();
        check_idle_reset("rst_c2");
        rst = 1'b0;
        req = '0;

        // Single write from requester 2, no lock
        req  = 4'b0100;
        lock = 4'b0000;
        wdata[2*WIDTH +: WIDTH] = 8'hA5;
        tick();
        check("single_c1_gnt",  32'(gnt),    32'h4);
        check("single_c1_busy", 32'(busy),   32'h1);
        check("single_c1_ack",  32'(wr_ack), 32'h0);
        check("single_c1_q",    32'(Q),      32'h00);
        tick();
        check("single_c2_q",    32'(Q),      32'hA5);
        check("single_c2_qbar", 32'(Q_bar),  32'h5A);
        check("single_c2_ack",  32'(wr_ack), 32'h1);
        check("single_c2_gnt",  32'(gnt),    32'h4);

        // Round robin over all four requesters
        do_reset();
        rr_gnt_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rr_q_exp   = '{8'h00, 8'h10, 8'h11, 8'h12, 8'h13};
        req  = 4'b1111;
        lock = 4'b0000;
        for (int i = 0; i < N_REQ; i++) wdata[i*WIDTH +: WIDTH] = 8'(8'h10 + i);
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("rr_c%0d_gnt", k + 1), 32'(gnt), 32'(rr_gnt_exp[k]));
            check($sformatf("rr_c%0d_q",   k + 1), 32'(Q),   32'(rr_q_exp[k]));
            check($sformatf("rr_c%0d_ack", k + 1), 32'(wr_ack), (k == 0) ? 32'h0 : 32'h1);
        end

        // Lock limit: requester 1 locks, requester 3 waits
        do_reset();
        req  = 4'b1010;
        lock = 4'b0010;
        wdata[1*WIDTH +: WIDTH] = 8'h21;
        wdata[3*WIDTH +: WIDTH] = 8'h43;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check($sformatf("lock_c%0d_gnt", k), 32'(gnt), (k <= 4) ? 32'h2 : 32'h8);
            check($sformatf("lock_c%0d_ack", k), 32'(wr_ack), (k >= 2) ? 32'h1 : 32'h0);
        end
        check("lock_c5_q", 32'(Q), 32'h21);

        // Request dropped during a locked grant
        do_reset();
        req  = 4'b0001;
        lock = 4'b0001;
        wdata[0 +: WIDTH] = 8'h3C;
        tick();
        check("drop_c1_gnt", 32'(gnt), 32'h1);
        tick();
        check("drop_c2_q",   32'(Q),      32'h3C);
        check("drop_c2_ack", 32'(wr_ack), 32'h1);
        check("drop_c2_gnt", 32'(gnt),    32'h1);
        req = 4'b0000;
        wdata[0 +: WIDTH] = 8'hFF;
        tick();
        check("drop_c3_ack",  32'(wr_ack), 32'h0);
        check("drop_c3_q",    32'(Q),      32'h3C);
        check("drop_c3_gnt",  32'(gnt),    32'h0);
        check("drop_c3_busy", 32'(busy),   32'h0);

        // Reset while requester 2 holds a locked grant with data written
        do_reset();
        req  = 4'b0100;
        lock = 4'b0100;
        wdata[2*WIDTH +: WIDTH] = 8'h77;
        tick();
        check("mrst_c1_gnt", 32'(gnt), 32'h4);
        tick();
        check("mrst_c2_q",   32'(Q),   32'h77);
        check("mrst_c2_gnt", 32'(gnt), 32'h4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_c3_gnt",  32'(gnt),    32'h0);
        check("mrst_c3_q",    32'(Q),      32'h00);
        check("mrst_c3_ack",  32'(wr_ack), 32'h0);
        check("mrst_c3_busy", 32'(busy),   32'h0);
        req  = 4'b1111;
        lock = 4'b0000;
        tick();
        check("mrst_c4_gnt", 32'(gnt), 32'h1);
        check("mrst_c4_q",   32'(Q),   32'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
